// File: rtl/rsa_exp_sequencer_if.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer_if
//
// Bundles every handshake/data signal of the modular-exponentiation sequencer:
//   i_*  job request from the RSA top level (base, R mod N, exponent, modulus)
//   o_*  result towards the RSA top level (base^e mod N, normal domain)
//   m_*  request channel towards the shared Montgomery multiplier
//   s_*  result channel from the shared Montgomery multiplier
//
// Modports:
//   master  the sequencer itself
//   slave   its environment (RSA top level plus the Montgomery multiplier)
// -----------------------------------------------------------------------------
interface rsa_exp_sequencer_if #(
   parameter int MOD_WIDTH = 256,
   parameter int EXP_WIDTH = 256
);

   // job request
   logic                 i_valid;
   logic                 i_ready;
   logic [MOD_WIDTH-1:0] i_base_mont;
   logic [MOD_WIDTH-1:0] i_one_mont;
   logic [EXP_WIDTH-1:0] i_exponent;
   logic [MOD_WIDTH-1:0] i_modulus;

   // job result
   logic                 o_valid;
   logic                 o_ready;
   logic [MOD_WIDTH-1:0] o_out;

   // multiplier request
   logic                 m_valid;
   logic                 m_ready;
   logic [MOD_WIDTH-1:0] m_a;
   logic [MOD_WIDTH-1:0] m_b;
   logic [MOD_WIDTH-1:0] m_modulus;

   // multiplier result
   logic                 s_valid;
   logic                 s_ready;
   logic [MOD_WIDTH-1:0] s_out;

   modport master (
      input  i_valid, i_base_mont, i_one_mont, i_exponent, i_modulus,
      output i_ready,
      output o_valid, o_out,
      input  o_ready,
      output m_valid, m_a, m_b, m_modulus,
      input  m_ready,
      input  s_valid, s_out,
      output s_ready
   );

   modport slave (
      output i_valid, i_base_mont, i_one_mont, i_exponent, i_modulus,
      input  i_ready,
      input  o_valid, o_out,
      output o_ready,
      input  m_valid, m_a, m_b, m_modulus,
      output m_ready,
      output s_valid, s_out,
      input  s_ready
   );

endinterface

// File: rtl/rsa_exp_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_exp_sequencer
//
// Computes base^e mod N by right-to-left square-and-multiply. The block owns
// no arithmetic: every product is delegated to one external Montgomery
// multiplier (result = a*b*R^-1 mod N, R = 2^MOD_WIDTH), with at most one
// multiplier transaction in flight.
//
// Operands arrive already in the Montgomery domain (base*R mod N and R mod N).
// After the exponent loop a final multiply by plain 1 takes the accumulator
// back to the normal domain.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset; abandons any job in progress
//   bus   rsa_exp_sequencer_if.master
//           i_valid/i_ready   job request, accepted only in IDLE
//           i_base_mont       base in Montgomery form
//           i_one_mont        R mod N (Montgomery one, initial accumulator)
//           i_exponent        exponent e
//           i_modulus         odd modulus N
//           o_valid/o_ready   result handshake, o_out = base^e mod N
//           m_valid/m_ready   multiplier request, operands m_a, m_b, m_modulus
//           s_valid/s_ready   multiplier result s_out
// -----------------------------------------------------------------------------
module rsa_exp_sequencer #(
   parameter int MOD_WIDTH = 256,
   parameter int EXP_WIDTH = 256
) (
   input  logic                clk,
   input  logic                rst,
   rsa_exp_sequencer_if.master bus
);

   localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_WIDTH - 1);

   typedef enum logic [3:0] {
      IDLE,
      CHECK,
      MUL_REQ,
      MUL_WAIT,
      SQR_REQ,
      SQR_WAIT,
      FIN_REQ,
      FIN_WAIT,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [MOD_WIDTH-1:0] acc_q,   acc_d;    // running product (Montgomery form)
   logic [MOD_WIDTH-1:0] sq_q,    sq_d;     // base^(2^idx) (Montgomery form)
   logic [EXP_WIDTH-1:0] exp_q,   exp_d;
   logic [MOD_WIDTH-1:0] mod_q,   mod_d;
   logic [IDX_W-1:0]     idx_q,   idx_d;    // exponent bit being processed

   logic last_bit;
   logic cur_bit;

   assign last_bit = (idx_q == LAST_IDX);
   assign cur_bit  = exp_q[idx_q];

   // The captured modulus accompanies every request unconditionally.
   assign bus.m_modulus = mod_q;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sq_q    <= '0;
         exp_q   <= '0;
         mod_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sq_q    <= sq_d;
         exp_q   <= exp_d;
         mod_q   <= mod_d;
         idx_q   <= idx_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   //
   // Request operands are driven straight from acc_q/sq_q. Those registers only
   // change on a result handshake, which cannot happen while a *_REQ state is
   // waiting for m_ready, so m_a/m_b are inherently stable until accepted.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      sq_d        = sq_q;
      exp_d       = exp_q;
      mod_d       = mod_q;
      idx_d       = idx_q;

      bus.i_ready = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_out   = '0;
      bus.m_valid = 1'b0;
      bus.m_a     = '0;
      bus.m_b     = '0;
      bus.s_ready = 1'b0;

      case (state_q)
         IDLE: begin
            bus.i_ready = 1'b1;
            if (bus.i_valid) begin
               acc_d   = bus.i_one_mont;
               sq_d    = bus.i_base_mont;
               exp_d   = bus.i_exponent;
               mod_d   = bus.i_modulus;
               idx_d   = '0;
               state_d = CHECK;
            end
         end

         CHECK: begin
            // Squaring is pointless after the final exponent bit, so a clear
            // last bit goes straight to the domain exit.
            if (cur_bit) begin
               state_d = MUL_REQ;
            end else if (last_bit) begin
               state_d = FIN_REQ;
            end else begin
               state_d = SQR_REQ;
            end
         end

         MUL_REQ: begin
            bus.m_valid = 1'b1;
            bus.m_a     = acc_q;
            bus.m_b     = sq_q;
            if (bus.m_ready) begin
               state_d = MUL_WAIT;
            end
         end

         MUL_WAIT: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               acc_d   = bus.s_out;
               state_d = last_bit ? FIN_REQ : SQR_REQ;
            end
         end

         SQR_REQ: begin
            bus.m_valid = 1'b1;
            bus.m_a     = sq_q;
            bus.m_b     = sq_q;
            if (bus.m_ready) begin
               state_d = SQR_WAIT;
            end
         end

         SQR_WAIT: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               sq_d    = bus.s_out;
               // Never reached with idx at its last value, so no wrap.
               idx_d   = idx_q + IDX_W'(1);
               state_d = CHECK;
            end
         end

         FIN_REQ: begin
            // Montgomery product with plain 1 strips the R factor.
            bus.m_valid = 1'b1;
            bus.m_a     = acc_q;
            bus.m_b     = MOD_WIDTH'(1);
            if (bus.m_ready) begin
               state_d = FIN_WAIT;
            end
         end

         FIN_WAIT: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               acc_d   = bus.s_out;
               state_d = DONE;
            end
         end

         DONE: begin
            bus.o_valid = 1'b1;
            bus.o_out   = acc_q;
            // Returning to IDLE (rather than accepting here) means a new job
            // can only start the cycle after the result handshake.
            if (bus.o_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
